// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state encoding and constants
package ps2_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} ps2_state_t;
   localparam int PS2_DATA_BITS = 8;
   localparam logic SYNC_RESET_LEVEL = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with wrap-bit pointers; dout reads 0 when empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   always_comb begin
      empty = wp == rp;
      full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      dout = empty ? '0 : mem[rp[AW-1:0]];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= do_push ? wp + 1'b1 : wp;
         rp <= do_pop ? rp + 1'b1 : rp;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: PS/2 device-to-host deframer feeding a show-ahead scan-code FIFO
module ps2_scan_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic [7:0] key_data,
   output logic       key_valid,
   output logic       frame_err,
   output logic       overflow
);
   localparam int TW = $clog2(TIMEOUT + 1);
   ps2_state_t state, state_n;
   logic [1:0] clk_sync, data_sync;
   logic clk_prev, fall, bit_in, timeout, push, err, full, empty, par;
   logic [2:0] bit_cnt;
   logic [PS2_DATA_BITS-1:0] shift;
   logic [TW-1:0] tcnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_sync <= {2{SYNC_RESET_LEVEL}};
         data_sync <= {2{SYNC_RESET_LEVEL}};
         clk_prev <= SYNC_RESET_LEVEL;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev <= clk_sync[1];
      end
   assign fall = clk_prev & ~clk_sync[1];
   assign bit_in = data_sync[1];
   assign timeout = state != IDLE && tcnt == TW'(TIMEOUT);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // a stalled frame wins over a coincident edge
   always_comb begin
      state_n = state;
      push = 1'b0;
      err = 1'b0;
      if (timeout) begin
         state_n = IDLE;
         err = 1'b1;
      end else if (fall)
         case (state)
            IDLE:   state_n = bit_in ? IDLE : DATA;
            DATA:   state_n = bit_cnt == 3'(PS2_DATA_BITS - 1) ? PARITY : DATA;
            PARITY: state_n = STOP;
            STOP: begin
               state_n = IDLE;
               push = bit_in && ^{shift, par};
               err = !push;
            end
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bit_cnt <= '0;
         shift <= '0;
         par <= 1'b0;
         tcnt <= '0;
         frame_err <= 1'b0;
         overflow <= 1'b0;
      end else begin
         frame_err <= err;
         tcnt <= (state == IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
         if (timeout) begin
            bit_cnt <= '0;
            shift <= '0;
         end else if (fall && state == IDLE) bit_cnt <= '0;
         else if (fall && state == DATA) begin
            shift <= {bit_in, shift[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fall && state == PARITY) par <= bit_in;
         if (push && full && !rd_en) overflow <= 1'b1;
      end
   sync_fifo #(.WIDTH(PS2_DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (shift),
      .pop   (rd_en),
      .dout  (key_data),
      .empty (empty),
      .full  (full)
   );
   assign key_valid = !empty;
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb_ps2_scan_fifo: directed and random PS/2 frames against a queue-based model
module tb_ps2_scan_fifo;
   localparam int DEPTH = 8;
   localparam int TO = 100;
   logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1, rd_en = 0;
   logic [7:0] key_data;
   logic key_valid, frame_err, overflow;
   ps2_scan_fifo #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
      .key_data(key_data), .key_valid(key_valid), .frame_err(frame_err), .overflow(overflow)
   );
   always #5 clk = ~clk;
   typedef struct {int at; bit err; logic [7:0] d;} ev_t;
   ev_t ev[$];
   logic [7:0] q[$];
   bit ovf_m, err_m, rnd_rd;
   int cyc, pop_cyc = -1, errors, checks, err_pulses, p0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // the model advances once per clock: pop the head, then land any frame that completes now
   task automatic step();
      @(posedge clk);
      cyc++;
      err_m = 0;
      if (!reset) begin
         if (rd_en && q.size() > 0) void'(q.pop_front());
         while (ev.size() > 0 && ev[0].at == cyc) begin
            if (ev[0].err) err_m = 1;
            else if (q.size() < DEPTH) q.push_back(ev[0].d);
            else ovf_m = 1;
            void'(ev.pop_front());
         end
      end
      #1 rd_en = (cyc == pop_cyc) || (rnd_rd && $urandom_range(0, 31) == 0);
   endtask
   task automatic ticks(int n);
      repeat (n) step();
   endtask
   task automatic do_reset(int n);
      reset = 1;
      q.delete();
      ev.delete();
      ovf_m = 0;
      err_m = 0;
      pop_cyc = -1;
      ticks(n);
      reset = 0;
   endtask
   // pin falls are seen three clocks later; a stalled frame errors TIMEOUT+1 clocks after that
   task automatic send_frame(logic [7:0] d, bit bad_par, bit stop, int h, int nbits, bit to_err, bit pop_at_push);
      logic [10:0] f;
      ev_t e;
      f = {stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         ticks(h);
         ps2_clk = 0;
         if (i == 10) begin
            e.at = cyc + 3; e.err = bad_par || !stop; e.d = d;
            ev.push_back(e);
            if (pop_at_push) pop_cyc = cyc + 2;
         end else if (i == nbits - 1 && to_err) begin
            e.at = cyc + 4 + TO; e.err = 1; e.d = 8'h00;
            ev.push_back(e);
         end
         ticks(h);
         ps2_clk = 1;
      end
      ps2_data = 1;
      if (to_err) ticks(TO + 10);
   endtask
   task automatic good(logic [7:0] d);
      send_frame(d, 0, 1, 10, 11, 0, 0);
      ticks(5);
   endtask
   task automatic pop_chk(string name, logic [7:0] e);
      chk(name, {key_valid, key_data}, {1'b1, e});
      rd_en = 1;
      step();
   endtask
   initial forever begin
      @(negedge clk);
      chk("valid", key_valid, q.size() != 0);
      chk("data", key_data, q.size() != 0 ? q[0] : 8'h00);
      chk("frame_err", frame_err, err_m);
      chk("overflow", overflow, ovf_m);
      if (frame_err) err_pulses++;
   end
   initial begin
      do_reset(3);
      chk("rst_out", {key_valid, key_data, frame_err, overflow}, 0);
      p0 = err_pulses;
      good(8'h1C);
      chk("single_data", {key_valid, key_data}, {1'b1, 8'h1C});
      chk("single_noerr", err_pulses - p0, 0);
      pop_chk("single_pop", 8'h1C);
      chk("single_empty", key_valid, 0);
      good(8'hF0);
      good(8'h1C);
      pop_chk("brk_f0", 8'hF0);
      pop_chk("brk_1c", 8'h1C);
      chk("brk_empty", key_valid, 0);
      p0 = err_pulses;
      send_frame(8'h1C, 1, 1, 10, 11, 0, 0);
      ticks(5);
      chk("badpar_err", err_pulses - p0, 1);
      chk("badpar_valid", key_valid, 0);
      good(8'h29);
      pop_chk("badpar_next", 8'h29);
      p0 = err_pulses;
      send_frame(8'h55, 0, 1, 10, 4, 1, 0);
      chk("to_err", err_pulses - p0, 1);
      chk("to_valid", key_valid, 0);
      good(8'h29);
      pop_chk("to_next", 8'h29);
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 6, 11, 0, 0);
      ticks(5);
      chk("ovf_set", overflow, 1);
      for (int i = 1; i <= 8; i++) pop_chk("ovf_pop", 8'(i));
      chk("ovf_sticky", {key_valid, overflow}, 2'b01);
      do_reset(2);
      chk("ovf_reset", overflow, 0);
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 6, 11, 0, i == 9);
      ticks(5);
      chk("ovf2_clear", overflow, 0);
      for (int i = 2; i <= 9; i++) pop_chk("ovf2_pop", 8'(i));
      chk("ovf2_empty", key_valid, 0);
      good(8'h33);
      send_frame(8'hA5, 0, 1, 10, 5, 0, 0);
      do_reset(2);
      chk("mid_rst_out", {key_valid, key_data, frame_err, overflow}, 0);
      good(8'h5A);
      pop_chk("mid_rst_next", 8'h5A);
      chk("mid_rst_empty", key_valid, 0);
      rnd_rd = 1;
      repeat (40) begin
         send_frame(8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0,
                    $urandom_range(3, 12), 11, 0, 0);
         ticks($urandom_range(0, 20));
      end
      rnd_rd = 0;
      ticks(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
